// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM->WB handshake and data bundle for wb_stage_reg.
//   slave  modport: the pipeline register's view. It consumes the in_* side and drives the out_* side.
//   master modport: the environment's view, covering both the MEM stage and the regfile/RVFI sink.
// Signals:
//   flush                             kill all held entries
//   in_valid / in_ready               upstream handshake
//   in_rd, in_load_regfile            destination register and its write flag
//   in_is_load, in_funct3             load qualifier and load width/sign
//   in_addr, in_mdr, in_wdata, in_pc  address, raw read word, non-load result, PC
//   out_valid / out_ready             downstream handshake (the commit point)
//   out_we, out_rd, out_wdata         regfile write port
//   out_pc, out_rmask, out_rdata      RVFI fields
//   commit                            out_valid & out_ready
interface wb_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic            in_load_regfile;
  logic            in_is_load;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_addr;
  logic [31:0]     in_mdr;
  logic [XLEN-1:0] in_wdata;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic            out_we;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_wdata;
  logic [PC_W-1:0] out_pc;
  logic [3:0]      out_rmask;
  logic [31:0]     out_rdata;
  logic            commit;

  modport slave (
    input  flush, in_valid, in_rd, in_load_regfile, in_is_load, in_funct3,
           in_addr, in_mdr, in_wdata, in_pc, out_ready,
    output in_ready, out_valid, out_we, out_rd, out_wdata, out_pc,
           out_rmask, out_rdata, commit
  );

  modport master (
    output flush, in_valid, in_rd, in_load_regfile, in_is_load, in_funct3,
           in_addr, in_mdr, in_wdata, in_pc, out_ready,
    input  in_ready, out_valid, out_we, out_rd, out_wdata, out_pc,
           out_rmask, out_rdata, commit
  );
endinterface

// File: rtl/wb_stage_reg.sv
// wb_stage_reg: MEM->WB pipeline register with a valid/ready handshake, an
// optional 2-entry skid buffer, flush, load alignment/extension and RVFI rmask.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  wb_stage_if.slave (see the interface file for the signal list)
// Parameters: XLEN (32/64), SKID (0 = single register, 1 = skid buffer), PC_W.
//
// state   | meaning
// --------+--------------------------------------------------
// S_EMPTY | nothing held, out_valid = 0
// S_ONE   | main entry presented
// S_FULL  | main presented and skid entry waiting (SKID=1 only)
module wb_stage_reg #(
  parameter int XLEN = 32,
  parameter int SKID = 1,
  parameter int PC_W = 32
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} state_t;

  typedef struct packed {
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
    logic [PC_W-1:0] pc;
    logic [3:0]      rmask;
    logic [31:0]     rdata;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, in_entry;
  logic   accept;
  logic   load_main_in, load_main_skid, load_skid;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_addr_hi;

  // Only the low two address bits steer load alignment.
  assign unused_addr_hi = ^bus.in_addr[XLEN-1:2];

  assign accept = bus.in_valid & bus.in_ready & ~bus.flush;

  // Build the entry as it will be stored.
  always_comb begin
    case (bus.in_addr[1:0])
      2'd0:    ld_byte = bus.in_mdr[7:0];
      2'd1:    ld_byte = bus.in_mdr[15:8];
      2'd2:    ld_byte = bus.in_mdr[23:16];
      default: ld_byte = bus.in_mdr[31:24];
    endcase
    ld_half = bus.in_addr[1] ? bus.in_mdr[31:16] : bus.in_mdr[15:0];

    in_entry       = '0;
    // The rd != 0 test is folded in here so that out_we needs only registered terms.
    in_entry.we    = bus.in_load_regfile & (bus.in_rd != 5'd0);
    in_entry.rd    = bus.in_rd;
    in_entry.pc    = bus.in_pc;
    in_entry.wdata = bus.in_wdata;
    if (bus.in_is_load) begin
      in_entry.rdata = bus.in_mdr;
      case (bus.in_funct3)
        3'b000: begin
          in_entry.wdata = XLEN'($signed(ld_byte));
          in_entry.rmask = 4'b0001 << bus.in_addr[1:0];
        end
        3'b100: begin
          in_entry.wdata = XLEN'(ld_byte);
          in_entry.rmask = 4'b0001 << bus.in_addr[1:0];
        end
        3'b001: begin
          in_entry.wdata = XLEN'($signed(ld_half));
          in_entry.rmask = bus.in_addr[1] ? 4'b1100 : 4'b0011;
        end
        3'b101: begin
          in_entry.wdata = XLEN'(ld_half);
          in_entry.rmask = bus.in_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          in_entry.wdata = XLEN'($signed(bus.in_mdr));
          in_entry.rmask = 4'b1111;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // With SKID=0 an accept in S_ONE implies out_ready, so S_FULL is unreachable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_ONE;
      S_ONE: begin
        if (accept && !bus.out_ready)      state_d = S_FULL;
        else if (!accept && bus.out_ready) state_d = S_EMPTY;
      end
      S_FULL:  if (bus.out_ready) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
    if (bus.flush) state_d = S_EMPTY;
  end

  always_comb begin
    if (SKID != 0) bus.in_ready = (state_q != S_FULL);
    else           bus.in_ready = (state_q == S_EMPTY) | bus.out_ready;
    bus.out_valid  = (state_q != S_EMPTY);
    bus.out_we     = bus.out_valid & main_q.we;
    bus.commit     = bus.out_valid & bus.out_ready;
    load_main_in   = accept & ((state_q == S_EMPTY) | ((state_q == S_ONE) & bus.out_ready));
    load_skid      = accept & (state_q == S_ONE) & ~bus.out_ready;
    load_main_skid = (state_q == S_FULL) & bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_entry;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_entry;
    end
  end

  assign bus.out_rd    = main_q.rd;
  assign bus.out_wdata = main_q.wdata;
  assign bus.out_pc    = main_q.pc;
  assign bus.out_rmask = main_q.rmask;
  assign bus.out_rdata = main_q.rdata;

endmodule

// File: doc/wb_stage_reg.md
# wb_stage_reg

Parametrised MEM→WB pipeline register for the RV32I pipeline, replacing the fixed-width, load-enable-only writeback latch. It adds a valid/ready handshake with an optional 2-entry skid buffer, a synchronous flush, and registered load-data alignment with sign/zero extension. It also generates the RVFI read mask. It sits between the MEM stage and the regfile write port; its output handshake is the commit point.

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64; loads extend to XLEN)
- SKID, 1, 0 = single register, 1 = 2-entry skid buffer
- PC_W, 32, PC width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous and active-high
- flush  in  1  kill all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  block can accept
- in_rd  in  5  destination register
- in_load_regfile  in  1  entry writes rd
- in_is_load  in  1  entry is op_load
- in_funct3  in  3  load funct3
- in_addr  in  XLEN  ALU result / load address
- in_mdr  in  32  raw memory read word
- in_wdata  in  XLEN  non-load writeback value (ALU, br_en, u_imm, pc+4, already muxed)
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  entry presented
- out_ready  in  1  downstream accepts
- out_we  out  1  regfile write enable
- out_rd  out  5  destination register
- out_wdata  out  XLEN  final writeback data
- out_pc  out  PC_W  entry PC
- out_rmask  out  4  RVFI mem_rmask (0 for non-loads)
- out_rdata  out  32  RVFI mem_rdata (raw in_mdr; 0 for non-loads)
- commit  out  1  out_valid & out_ready

## Operation
- Accept = in_valid & in_ready & ~flush. Result fields are computed combinationally from inputs and stored at accept. Outputs are driven only from registers.
- Load data: byte = in_mdr[8*addr[1:0] +: 8]; half = in_mdr[16*addr[1] +: 16].
  - lb sign-extends byte; lbu zero-extends byte.
  - lh sign-extends half; lhu zero-extends half.
  - lw sign-extends in_mdr to XLEN.
  - Other funct3 values are treated as lw.
- rmask: lb/lbu = 0001<<addr[1:0]; lh/lhu = 0011<<{addr[1],0}; lw and others = 1111.
- Misaligned addresses are not trapped. The low address bits select the data as above.
- out_we = out_valid & stored load_regfile & (out_rd != 0).
- SKID=0: one register. in_ready = ~out_valid | out_ready.
- SKID=1 states: EMPTY, ONE (main valid), FULL (main+skid valid). in_ready = ~skid_valid, registered.
  - EMPTY + accept → ONE.
  - ONE + accept & out_ready → ONE (main replaced).
  - ONE + accept & ~out_ready → FULL (new entry to skid).
  - ONE + ~accept & out_ready → EMPTY.
  - FULL + out_ready → ONE (skid moves to main).
  - FULL cannot accept.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- flush: next cycle all valid bits are 0 (→ EMPTY). Flush beats a simultaneous accept and a simultaneous drain. commit is still asserted in the flush cycle if out_valid & out_ready, because that entry retires.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is at the outputs after edge N, with out_valid high.
- Throughput is 1 entry/cycle when out_ready is held high.
- in_ready after the accept edge reflects the new state. With SKID=1 it never depends combinationally on out_ready.
- Reset drives every state and output to 0: out_valid, out_we, commit, out_rd, out_wdata, out_pc, out_rmask, out_rdata. in_ready is 1 in the cycle after reset.
- Reset asserted mid-operation discards all entries, identically to flush, and zeroes data registers.
- Data registers hold while their entry is held. There are no output changes without a handshake.

## Test plan
- lb, addr=0x..1, mdr=0x80FF7F00 → out_wdata=0x0000007F, rmask=0010, out_rdata=0x80FF7F00. lh, addr=0x..2 → 0xFFFF80FF, rmask=1100. lhu same address → 0x000080FF.
- lw, addr=0x..0, mdr=0x80000001, XLEN=64 → out_wdata=0xFFFFFFFF80000001, rmask=1111. A non-load with in_wdata=0x1234 → out_wdata=0x1234, rmask=0, rdata=0.
- SKID=1, out_ready=0, push A,B: in_ready falls after B and B is not lost. Raise out_ready → A then B on consecutive cycles, with commit high both cycles, then EMPTY.
- flush in the same cycle as in_valid=1 while ONE → next cycle out_valid=0, and the new entry never appears.
- rd=0 with load_regfile=1 → out_valid=1, out_we=0. A reset pulse while FULL → next cycle all outputs 0 and in_ready=1.
- Random in_valid/out_ready (SKID 0 and 1) against a FIFO reference model → identical committed sequence, with no bubbles when out_ready is held high.
